mul_arbiter: RTL and testbench

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/ode_pkg.sv | 12 +
 rtl/mul_arbiter_if.sv | 45 ++++
 rtl/rr_pick2.sv | 17 +
 rtl/mul_arbiter.sv | 118 +++++++++++
 tb/tb_mul_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ode_pkg.sv
// Shared constants for the ODE datapath: default word width and arbiter state encodings.
package ode_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mul_arbiter_if.sv
// Bundle of the two requester ports and the shared-multiplier port of mul_arbiter.
interface mul_arbiter_if #(parameter int WIDTH = ode_pkg::WIDTH_DEF);

  logic             req0_start;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_done;
  logic [WIDTH-1:0] req0_result;
  logic             req0_overflow;

  logic             req1_start;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_done;
  logic [WIDTH-1:0] req1_result;
  logic             req1_overflow;

  logic             mul_start;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic             mul_done;
  logic [WIDTH-1:0] mul_result;
  logic             mul_overflow;

  logic             busy;
  logic             grant;

  // master: requesters plus the multiplier; slave: the arbiter itself
  modport master (
    output req0_start, req0_a, req0_b, req1_start, req1_a, req1_b,
    output mul_done, mul_result, mul_overflow,
    input  req0_done, req0_result, req0_overflow,
    input  req1_done, req1_result, req1_overflow,
    input  mul_start, mul_a, mul_b, busy, grant
  );

  modport slave (
    input  req0_start, req0_a, req0_b, req1_start, req1_a, req1_b,
    input  mul_done, mul_result, mul_overflow,
    output req0_done, req0_result, req0_overflow,
    output req1_done, req1_result, req1_overflow,
    output mul_start, mul_a, mul_b, busy, grant
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin winner selection: the requester not served last wins a tie.
module rr_pick2 (
  input  logic [1:0] pending,
  input  logic       last,
  output logic       winner,
  output logic       valid
);

  assign valid = |pending;

  always_comb begin
    winner = 1'b0;
    if (&pending) winner = ~last;
    else          winner = pending[1];
  end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one multi-cycle multiplier between two requesters (step control, integrator core)
// with one queued operation per requester and round-robin arbitration.
module mul_arbiter
  import ode_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  mul_arbiter_if.slave  bus
);

  arb_state_e            state_q, state_d;
  logic [1:0]            pending_q, pending_d;
  logic                  last_q, last_d;
  logic                  grant_q, grant_d;
  logic [1:0][WIDTH-1:0] opa_q, opa_d;
  logic [1:0][WIDTH-1:0] opb_q, opb_d;
  logic [1:0][WIDTH-1:0] res_q, res_d;
  logic [1:0]            ovf_q, ovf_d;
  logic [1:0]            done_q, done_d;

  logic [1:0]            start;
  logic [1:0][WIDTH-1:0] a_in, b_in;
  logic                  pick_win, pick_vld;

  assign start = {bus.req1_start, bus.req0_start};
  assign a_in  = {bus.req1_a, bus.req0_a};
  assign b_in  = {bus.req1_b, bus.req0_b};

  rr_pick2 u_pick (
    .pending (pending_q),
    .last    (last_q),
    .winner  (pick_win),
    .valid   (pick_vld)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    last_d    = last_q;
    grant_d   = grant_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    ovf_d     = ovf_q;
    done_d    = 2'b00;

    // A start is only taken when that requester has nothing queued or in flight.
    for (int i = 0; i < 2; i++) begin
      if (start[i] && !pending_q[i]) begin
        pending_d[i] = 1'b1;
        opa_d[i]     = a_in[i];
        opb_d[i]     = b_in[i];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d = pick_win;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.mul_done) begin
          res_d[grant_q]     = bus.mul_result;
          ovf_d[grant_q]     = bus.mul_overflow;
          done_d[grant_q]    = 1'b1;
          pending_d[grant_q] = 1'b0;
          last_d             = grant_q;
          state_d            = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pending_q <= 2'b00;
      last_q    <= 1'b1;
      grant_q   <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      res_q     <= '0;
      ovf_q     <= 2'b00;
      done_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      res_q     <= res_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  // Operands stay on the multiplier bus from ISSUE through WAIT and are zeroed when idle.
  assign bus.mul_start     = (state_q == ST_ISSUE);
  assign bus.mul_a         = (state_q == ST_IDLE) ? '0 : opa_q[grant_q];
  assign bus.mul_b         = (state_q == ST_IDLE) ? '0 : opb_q[grant_q];
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.grant         = (state_q == ST_IDLE) ? 1'b0 : grant_q;

  assign bus.req0_done     = done_q[0];
  assign bus.req0_result   = res_q[0];
  assign bus.req0_overflow = ovf_q[0];
  assign bus.req1_done     = done_q[1];
  assign bus.req1_result   = res_q[1];
  assign bus.req1_overflow = ovf_q[1];

endmodule

// File: tb/tb_mul_arbiter.sv
// Randomized and directed bench for mul_arbiter against a transaction-timeline reference model.
module tb_mul_arbiter;
  import ode_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_arbiter_if #(.WIDTH(W)) bus();
  mul_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // reference model: outstanding work per requester and the expected timeline of the shared multiplier
  bit         m_out[2];
  int         m_acc[2];
  logic [W-1:0] m_a[2], m_b[2], m_res[2];
  bit         m_ovf[2];
  int         m_done_at[2];
  bit         m_act, m_srv, m_last;
  int         m_issue_at, m_mdone_at;

  int  lat_cfg = 4;
  bit  force_ovf1 = 0;
  bit  stray_en = 0;
  bit  stray_now = 0;
  int  auto_left = 0;
  int  n_mstart = 0;
  int  n_done[2];
  int  glog[$];

  bit           s_start[2];
  logic [W-1:0] s_a[2], s_b[2];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Q16.16 multiply as the external multiplier would compute it
  task automatic mul_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic o);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    r = p[47:16];
    o = |p[63:48];
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_out[i] = 0; m_acc[i] = 0; m_a[i] = '0; m_b[i] = '0;
      m_res[i] = '0; m_ovf[i] = 0; m_done_at[i] = -10;
      s_start[i] = 0;
    end
    m_act = 0; m_srv = 0; m_last = 1;
    m_issue_at = -10; m_mdone_at = -10;
  endtask

  task automatic clear_counts();
    n_mstart = 0; n_done[0] = 0; n_done[1] = 0;
    glog.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_val("pre_rst_busy", 64'(bus.busy), 64'(m_act));
    rst = 1'b0;
    bus.req0_start = 0; bus.req1_start = 0; bus.mul_done = 0;
    #1;
    check_val("rst_busy", 64'(bus.busy), 64'd0);
    check_val("rst_grant", 64'(bus.grant), 64'd0);
    check_val("rst_mul_start", 64'(bus.mul_start), 64'd0);
    check_val("rst_mul_a", 64'(bus.mul_a), 64'd0);
    check_val("rst_req0_done", 64'(bus.req0_done), 64'd0);
    check_val("rst_req1_result", 64'(bus.req1_result), 64'd0);
    check_val("rst_req1_overflow", 64'(bus.req1_overflow), 64'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic cycle();
    logic [W-1:0] r;
    logic o;
    bit md;
    int lat;
    bit e0, e1;
    @(negedge clk);
    check_val("busy", 64'(bus.busy), 64'(m_act));
    check_val("grant", 64'(bus.grant), m_act ? 64'(m_srv) : 64'd0);
    check_val("mul_start", 64'(bus.mul_start), 64'(m_issue_at == cyc));
    check_val("mul_a", 64'(bus.mul_a), m_act ? 64'(m_a[m_srv]) : 64'd0);
    check_val("mul_b", 64'(bus.mul_b), m_act ? 64'(m_b[m_srv]) : 64'd0);
    check_val("req0_done", 64'(bus.req0_done), 64'(m_done_at[0] == cyc));
    check_val("req0_result", 64'(bus.req0_result), 64'(m_res[0]));
    check_val("req0_overflow", 64'(bus.req0_overflow), 64'(m_ovf[0]));
    check_val("req1_done", 64'(bus.req1_done), 64'(m_done_at[1] == cyc));
    check_val("req1_result", 64'(bus.req1_result), 64'(m_res[1]));
    check_val("req1_overflow", 64'(bus.req1_overflow), 64'(m_ovf[1]));
    if (bus.mul_start) begin n_mstart++; glog.push_back(int'(bus.grant)); end
    if (bus.req0_done) n_done[0]++;
    if (bus.req1_done) n_done[1]++;

    md = m_act && (cyc == m_mdone_at);
    r = '0; o = 0;
    if (md) begin
      mul_ref(m_a[m_srv], m_b[m_srv], r, o);
      if (force_ovf1 && m_srv) o = 1;
      bus.mul_done = 1; bus.mul_result = r; bus.mul_overflow = o;
    end else begin
      bus.mul_done = !m_act && (stray_now || (stray_en && $urandom_range(0, 9) == 0));
      bus.mul_result = $urandom;
      bus.mul_overflow = 1'($urandom_range(0, 1));
    end

    for (int i = 0; i < 2; i++)
      if (auto_left > 0 && m_done_at[i] == cyc) begin
        s_start[i] = 1; s_a[i] = $urandom_range(0, 32'h0003_ffff); s_b[i] = $urandom_range(0, 32'h0003_ffff);
        auto_left--;
      end
    bus.req0_start = s_start[0]; bus.req0_a = s_a[0]; bus.req0_b = s_b[0];
    bus.req1_start = s_start[1]; bus.req1_a = s_a[1]; bus.req1_b = s_b[1];

    for (int i = 0; i < 2; i++)
      if (s_start[i] && !m_out[i]) begin
        m_out[i] = 1; m_acc[i] = cyc; m_a[i] = s_a[i]; m_b[i] = s_b[i];
      end
    if (md) begin
      m_res[m_srv] = r; m_ovf[m_srv] = o; m_done_at[m_srv] = cyc + 1;
      m_out[m_srv] = 0; m_last = m_srv; m_act = 0;
    end else if (!m_act) begin
      e0 = m_out[0] && (m_acc[0] < cyc);
      e1 = m_out[1] && (m_acc[1] < cyc);
      if (e0 || e1) begin
        m_srv = (e0 && e1) ? !m_last : e1;
        lat = (lat_cfg > 0) ? lat_cfg : $urandom_range(1, 5);
        m_act = 1; m_issue_at = cyc + 1; m_mdone_at = cyc + 1 + lat;
      end
    end
    s_start[0] = 0; s_start[1] = 0; stray_now = 0;
    cyc++;
  endtask

  initial begin
    rst = 1'b0;
    bus.req0_start = 0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_start = 0; bus.req1_a = '0; bus.req1_b = '0;
    bus.mul_done = 0; bus.mul_result = '0; bus.mul_overflow = 0;
    model_reset();
    do_reset();

    // single uncontended request, multiplier latency 4
    clear_counts(); lat_cfg = 4;
    s_start[0] = 1; s_a[0] = 32'h0002_0000; s_b[0] = 32'h0003_0000;
    repeat (12) cycle();
    check_val("single_mstarts", 64'(n_mstart), 64'd1);
    check_val("single_done0", 64'(n_done[0]), 64'd1);
    check_val("single_done1", 64'(n_done[1]), 64'd0);
    check_val("single_result", 64'(bus.req0_result), 64'h0006_0000);

    // simultaneous starts straight after reset
    do_reset(); clear_counts(); lat_cfg = 3;
    s_start[0] = 1; s_a[0] = 32'h0001_8000; s_b[0] = 32'h0004_0000;
    s_start[1] = 1; s_a[1] = 32'h0002_0000; s_b[1] = 32'h0000_8000;
    repeat (20) cycle();
    check_val("simul_mstarts", 64'(n_mstart), 64'd2);
    check_val("simul_first", 64'(glog.size() > 0 ? glog[0] : 9), 64'd0);
    check_val("simul_second", 64'(glog.size() > 1 ? glog[1] : 9), 64'd1);
    check_val("simul_res0", 64'(bus.req0_result), 64'h0006_0000);
    check_val("simul_res1", 64'(bus.req1_result), 64'h0001_0000);

    // fairness: both restart on each done, six operations total
    do_reset(); clear_counts(); lat_cfg = 2; auto_left = 4;
    s_start[0] = 1; s_a[0] = 32'h0001_0000; s_b[0] = 32'h0002_0000;
    s_start[1] = 1; s_a[1] = 32'h0003_0000; s_b[1] = 32'h0001_0000;
    repeat (50) cycle();
    check_val("fair_count", 64'(glog.size()), 64'd6);
    for (int k = 0; k < 6; k++)
      check_val($sformatf("fair_grant%0d", k), 64'(k < glog.size() ? glog[k] : 9), 64'(k % 2));

    // duplicate start while pending keeps the first operands
    clear_counts(); lat_cfg = 4;
    s_start[1] = 1; s_a[1] = 32'h0003_0000; s_b[1] = 32'h0002_0000;
    cycle(); cycle();
    s_start[1] = 1; s_a[1] = 32'h0007_0000; s_b[1] = 32'h0007_0000;
    repeat (14) cycle();
    check_val("dup_mstarts", 64'(n_mstart), 64'd1);
    check_val("dup_done1", 64'(n_done[1]), 64'd1);
    check_val("dup_result", 64'(bus.req1_result), 64'h0006_0000);

    // overflow flagged by the multiplier for requester 1 only
    clear_counts(); force_ovf1 = 1; lat_cfg = 3;
    s_start[0] = 1; s_a[0] = 32'h0001_0000; s_b[0] = 32'h0001_0000;
    s_start[1] = 1; s_a[1] = 32'h0001_0000; s_b[1] = 32'h0001_0000;
    repeat (20) cycle();
    check_val("ovf_req1", 64'(bus.req1_overflow), 64'd1);
    check_val("ovf_req0", 64'(bus.req0_overflow), 64'd0);
    check_val("ovf_dones", 64'(n_done[0] + n_done[1]), 64'd2);
    force_ovf1 = 0;

    // reset during WAIT followed by a late mul_done
    clear_counts(); lat_cfg = 5;
    s_start[0] = 1; s_a[0] = 32'h0002_0000; s_b[0] = 32'h0002_0000;
    for (int k = 0; k < 20 && !(m_act && cyc >= m_issue_at + 1); k++) cycle();
    check_val("mid_reached_wait", 64'(m_act && cyc >= m_issue_at + 1), 64'd1);
    do_reset();
    stray_now = 1;
    repeat (5) cycle();
    check_val("mid_no_done", 64'(n_done[0] + n_done[1]), 64'd0);
    check_val("mid_idle", 64'(bus.busy), 64'd0);
    lat_cfg = 2;
    s_start[1] = 1; s_a[1] = 32'h0000_4000; s_b[1] = 32'h0008_0000;
    repeat (10) cycle();
    check_val("mid_next_done", 64'(n_done[1]), 64'd1);
    check_val("mid_next_result", 64'(bus.req1_result), 64'h0002_0000);

    // random traffic with stray mul_done pulses while idle
    lat_cfg = 0; stray_en = 1;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        s_start[i] = ($urandom_range(0, 3) == 0);
        s_a[i] = $urandom;
        s_b[i] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 32'h0004_0000));
      end
      cycle();
    end
    stray_en = 0;
    repeat (20) cycle();
    check_val("drain_busy", 64'(bus.busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
